// File: rtl/gtfwizard_mac_drp_reconfig_pkg.sv
// Shared definitions for the RX buffer-bypass DRP reconfiguration block:
// FSM state encodings, DRP bus widths, table size and a helper that
// slices one entry out of the packed per-register parameter vectors.
package gtfwizard_mac_drp_reconfig_pkg;

  localparam int DRP_ADDR_W   = 10;
  localparam int DRP_DATA_W   = 16;
  localparam int DRP_MAX_REGS = 4;
  localparam int DRP_IDX_W    = 2;

  // The numeric values are visible on the debug state output, so they are fixed.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RD_REQ   = 4'd1,
    ST_RD_WAIT  = 4'd2,
    ST_WR_REQ   = 4'd3,
    ST_WR_WAIT  = 4'd4,
    ST_VFY_REQ  = 4'd5,
    ST_VFY_WAIT = 4'd6,
    ST_NEXT     = 4'd7,
    ST_DONE     = 4'd8,
    ST_ERROR    = 4'd9
  } drp_state_e;

  function automatic logic [DRP_ADDR_W-1:0] drp_entry_addr(
    input logic [DRP_MAX_REGS*DRP_ADDR_W-1:0] vec,
    input logic [DRP_IDX_W-1:0]               idx
  );
    return vec[DRP_ADDR_W*idx +: DRP_ADDR_W];
  endfunction

  function automatic logic [DRP_DATA_W-1:0] drp_entry_data(
    input logic [DRP_MAX_REGS*DRP_DATA_W-1:0] vec,
    input logic [DRP_IDX_W-1:0]               idx
  );
    return vec[DRP_DATA_W*idx +: DRP_DATA_W];
  endfunction

endpackage

// File: rtl/gtfwizard_mac_rx_drp_sync_reconfig_if.sv
// GTF channel DRP port bundle. The reconfiguration FSM is the master;
// the channel (or a bus model) is the slave.
interface gtfwizard_mac_rx_drp_sync_reconfig_if;
  import gtfwizard_mac_drp_reconfig_pkg::*;

  logic [DRP_ADDR_W-1:0] drpaddr_out;
  logic                  drpen_out;
  logic                  drpwe_out;
  logic [DRP_DATA_W-1:0] drpdi_out;
  logic [DRP_DATA_W-1:0] drpdo_in;
  logic                  drprdy_in;

  modport master (
    output drpaddr_out, drpen_out, drpwe_out, drpdi_out,
    input  drpdo_in, drprdy_in
  );

  modport slave (
    input  drpaddr_out, drpen_out, drpwe_out, drpdi_out,
    output drpdo_in, drprdy_in
  );

endinterface

// File: rtl/gtfwizard_mac_drp_reconfig_sync2.sv
// Two-flop synchroniser for a single asynchronous level into the DRP clock.
module gtfwizard_mac_drp_reconfig_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Plain two-stage shift; the first stage is allowed to go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gtfwizard_mac_rx_drp_sync_reconfig.sv
// DRP read-modify-write sequencer that switches the GTF RX buffer-bypass
// alignment between manual mode and auto mode. Walks P_NUM_REGS table
// entries, each one a read, a masked merge and a write, then raises done
// until the controller drops its request.
// Optional build macro GTF_DRP_RECONFIG_VERIFY_EN adds a read-back of every
// write and flags an error if the masked field did not stick.
module gtfwizard_mac_rx_drp_sync_reconfig
  import gtfwizard_mac_drp_reconfig_pkg::*;
#(
  parameter int          P_NUM_REGS    = 3,
  parameter logic [39:0] P_REG_ADDR    = 40'h0,
  parameter logic [63:0] P_REG_MASK    = 64'h0,
  parameter logic [63:0] P_REG_VAL_AM  = 64'h0,
  parameter logic [63:0] P_REG_VAL_MM  = 64'h0,
  parameter int          P_DRP_TIMEOUT = 1023
) (
  input  logic       gtwiz_drp_reconfig_clk_in,
  input  logic       gtwiz_drp_reconfig_reset_in,
  input  logic       drp_reconfig_rdy_in,
  input  logic       drp_switch_am_in,
  output logic       drp_reconfig_done_out,
  output logic       drp_reconfig_error_out,
  output logic [3:0] sm_drp_reconfig_out,
  gtfwizard_mac_rx_drp_sync_reconfig_if.master drp
);

  localparam int                   TMO_W    = $clog2(P_DRP_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(P_DRP_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]     TMO_ONE  = TMO_W'(1);
  localparam logic [DRP_IDX_W-1:0] LAST_IDX = DRP_IDX_W'(P_NUM_REGS - 1);
  localparam logic [DRP_IDX_W-1:0] IDX_ONE  = DRP_IDX_W'(1);

  logic clk;
  logic rst;
  assign clk = gtwiz_drp_reconfig_clk_in;
  assign rst = gtwiz_drp_reconfig_reset_in;

  logic rdy_sync;
  logic am_sync;
  logic rdy_prev_q;
  logic start;

  drp_state_e            state_q, state_d;
  logic [DRP_IDX_W-1:0]  idx_q, idx_d;
  logic                  mode_am_q, mode_am_d;
  logic [DRP_DATA_W-1:0] wdata_q, wdata_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic [DRP_ADDR_W-1:0] cur_addr;
  logic [DRP_DATA_W-1:0] cur_mask;
  logic [DRP_DATA_W-1:0] cur_val;
  logic                  tmo_hit;

  gtfwizard_mac_drp_reconfig_sync2 u_sync_rdy (
    .clk (clk),
    .rst (rst),
    .d   (drp_reconfig_rdy_in),
    .q   (rdy_sync)
  );

  gtfwizard_mac_drp_reconfig_sync2 u_sync_am (
    .clk (clk),
    .rst (rst),
    .d   (drp_switch_am_in),
    .q   (am_sync)
  );

  assign start    = rdy_sync & ~rdy_prev_q;
  assign cur_addr = drp_entry_addr(P_REG_ADDR, idx_q);
  assign cur_mask = drp_entry_data(P_REG_MASK, idx_q);
  assign cur_val  = mode_am_q ? drp_entry_data(P_REG_VAL_AM, idx_q)
                              : drp_entry_data(P_REG_VAL_MM, idx_q);
  assign tmo_hit  = (tmo_q == TMO_LAST);

  // State, table index, latched mode, merged write data and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      mode_am_q  <= 1'b0;
      wdata_q    <= '0;
      tmo_q      <= '0;
      rdy_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_am_q  <= mode_am_d;
      wdata_q    <= wdata_d;
      tmo_q      <= tmo_d;
      rdy_prev_q <= rdy_sync;
    end
  end

  // Sequencer: each *_REQ state strobes drpen once, each *_WAIT waits for
  // drprdy with a bounded counter that is cleared on the way in.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    mode_am_d        = mode_am_q;
    wdata_d          = wdata_q;
    tmo_d            = tmo_q;
    drp.drpen_out    = 1'b0;
    drp.drpwe_out    = 1'b0;
    drp.drpaddr_out  = '0;
    drp.drpdi_out    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_am_d = am_sync;
          idx_d     = '0;
          state_d   = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        drp.drpen_out   = 1'b1;
        drp.drpaddr_out = cur_addr;
        tmo_d           = '0;
        state_d         = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (drp.drprdy_in) begin
          wdata_d = (drp.drpdo_in & ~cur_mask) | (cur_val & cur_mask);
          state_d = ST_WR_REQ;
        end else if (tmo_hit) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      ST_WR_REQ: begin
        drp.drpen_out   = 1'b1;
        drp.drpwe_out   = 1'b1;
        drp.drpaddr_out = cur_addr;
        drp.drpdi_out   = wdata_q;
        tmo_d           = '0;
        state_d         = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (drp.drprdy_in) begin
`ifdef GTF_DRP_RECONFIG_VERIFY_EN
          state_d = ST_VFY_REQ;
`else
          state_d = ST_NEXT;
`endif
        end else if (tmo_hit) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
`ifdef GTF_DRP_RECONFIG_VERIFY_EN
      ST_VFY_REQ: begin
        drp.drpen_out   = 1'b1;
        drp.drpaddr_out = cur_addr;
        tmo_d           = '0;
        state_d         = ST_VFY_WAIT;
      end
      ST_VFY_WAIT: begin
        if (drp.drprdy_in) begin
          if (((drp.drpdo_in ^ wdata_q) & cur_mask) != '0) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (tmo_hit) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
`endif
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = ST_RD_REQ;
        end
      end
      ST_DONE: begin
        if (!rdy_sync) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ERROR is only left through reset, so decoding it gives the sticky flag.
  always_comb begin
    drp_reconfig_done_out  = (state_q == ST_DONE);
    drp_reconfig_error_out = (state_q == ST_ERROR);
    sm_drp_reconfig_out    = state_q;
  end

endmodule

// File: tb/tb_gtfwizard_mac_rx_drp_sync_reconfig.sv
// Directed bench for the DRP reconfiguration sequencer. Two instances: a
// three-entry table and a single-entry table, each with its own DRP memory
// model that logs every strobe as {we, addr, write data}.
module tb_gtfwizard_mac_rx_drp_sync_reconfig;
  import gtfwizard_mac_drp_reconfig_pkg::*;

`ifdef GTF_DRP_RECONFIG_VERIFY_EN
  localparam int ACC_PER_ENTRY = 3;
`else
  localparam int ACC_PER_ENTRY = 2;
`endif

  logic clk;
  logic reset;
  logic rdy1, am1, done1, err1;
  logic rdy3, am3, done3, err3;
  logic [3:0] sm1, sm3;

  gtfwizard_mac_rx_drp_sync_reconfig_if drp1 ();
  gtfwizard_mac_rx_drp_sync_reconfig_if drp3 ();

  gtfwizard_mac_rx_drp_sync_reconfig #(
    .P_NUM_REGS    (3),
    .P_REG_ADDR    ({10'h000, 10'h1F0, 10'h0A3, 10'h05A}),
    .P_REG_MASK    (64'h0000_8001_00F0_0300),
    .P_REG_VAL_AM  (64'h0000_8000_00A0_0200),
    .P_REG_VAL_MM  (64'h0000_0001_0050_0100),
    .P_DRP_TIMEOUT (15)
  ) dut3 (
    .gtwiz_drp_reconfig_clk_in   (clk),
    .gtwiz_drp_reconfig_reset_in (reset),
    .drp_reconfig_rdy_in         (rdy3),
    .drp_switch_am_in            (am3),
    .drp_reconfig_done_out       (done3),
    .drp_reconfig_error_out      (err3),
    .sm_drp_reconfig_out         (sm3),
    .drp                         (drp3)
  );

  // Entry 1 is populated but must never be touched with P_NUM_REGS=1.
  gtfwizard_mac_rx_drp_sync_reconfig #(
    .P_NUM_REGS    (1),
    .P_REG_ADDR    ({10'h000, 10'h000, 10'h0A3, 10'h05A}),
    .P_REG_MASK    (64'h0000_0000_00F0_0300),
    .P_REG_VAL_AM  (64'h0000_0000_00A0_0200),
    .P_REG_VAL_MM  (64'h0000_0000_0050_0100),
    .P_DRP_TIMEOUT (15)
  ) dut1 (
    .gtwiz_drp_reconfig_clk_in   (clk),
    .gtwiz_drp_reconfig_reset_in (reset),
    .drp_reconfig_rdy_in         (rdy1),
    .drp_switch_am_in            (am1),
    .drp_reconfig_done_out       (done1),
    .drp_reconfig_error_out      (err1),
    .sm_drp_reconfig_out         (sm1),
    .drp                         (drp1)
  );

  // Hand-computed merges: initial memory 0xFFFF / 0x1234 / 0x0F0F.
  logic [9:0]  exp_addr [3] = '{10'h05A, 10'h0A3, 10'h1F0};
  logic [15:0] exp_am   [3] = '{16'hFEFF, 16'h12A4, 16'h8F0E};
  logic [15:0] exp_mm   [3] = '{16'hFDFF, 16'h1254, 16'h0F0F};

  int compared   = 0;
  int mismatched = 0;

  // Model state; only the negedge process below writes these.
  logic [15:0] mem1 [1024];
  logic [15:0] mem3 [1024];
  logic [26:0] log1 [$];
  logic [26:0] log3 [$];
  logic        mem_ready = 1'b0;
  int          cyc = 0;
  logic        busy1 = 0, busy3 = 0;
  int          cnt1 = 0, cnt3 = 0;
  logic [15:0] rdata1 = 0, rdata3 = 0;
  logic        pend_we3 = 0, last_we3 = 0;
  logic [9:0]  last_addr3 = 0;
  int          en_cnt3 = 0;
  int          rise3 = 0;
  logic        done3_prev = 0;
  int          wr_rdy_cyc3 = 0;
  int          done_cyc3 = 0;

  // Knobs driven by the stimulus process.
  int   lat3 = 1;
  logic no_rdy3 = 0;
  logic corrupt3 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  // DRP memory models and monitors, all evaluated on the falling edge.
  always @(negedge clk) begin
    if (!mem_ready) begin
      foreach (mem1[i]) mem1[i] = 16'h0000;
      foreach (mem3[i]) mem3[i] = 16'h0000;
      mem1[10'h05A] = 16'hFFFF;
      mem1[10'h0A3] = 16'h1234;
      mem3[10'h05A] = 16'hFFFF;
      mem3[10'h0A3] = 16'h1234;
      mem3[10'h1F0] = 16'h0F0F;
      mem_ready = 1'b1;
    end
    cyc = cyc + 1;

    drp3.drprdy_in = 1'b0;
    if (busy3) begin
      if (cnt3 == 0) begin
        busy3 = 1'b0;
        if (!no_rdy3) begin
          drp3.drprdy_in = 1'b1;
          drp3.drpdo_in  = rdata3;
          if (pend_we3) wr_rdy_cyc3 = cyc;
        end
      end else begin
        cnt3 = cnt3 - 1;
      end
    end
    if (drp3.drpen_out) begin
      en_cnt3 = en_cnt3 + 1;
      log3.push_back({drp3.drpwe_out, drp3.drpaddr_out,
                      drp3.drpwe_out ? drp3.drpdi_out : 16'h0000});
      if (drp3.drpwe_out) mem3[drp3.drpaddr_out] = drp3.drpdi_out;
      rdata3 = mem3[drp3.drpaddr_out];
      if (corrupt3 && !drp3.drpwe_out && last_we3 && last_addr3 == drp3.drpaddr_out)
        rdata3 = rdata3 ^ 16'h0100;
      last_we3   = drp3.drpwe_out;
      last_addr3 = drp3.drpaddr_out;
      pend_we3   = drp3.drpwe_out;
      busy3      = 1'b1;
      cnt3       = lat3 - 1;
    end
    if (done3 && !done3_prev) begin
      rise3     = rise3 + 1;
      done_cyc3 = cyc;
    end
    done3_prev = done3;

    drp1.drprdy_in = 1'b0;
    if (busy1) begin
      busy1 = 1'b0;
      drp1.drprdy_in = 1'b1;
      drp1.drpdo_in  = rdata1;
    end
    if (drp1.drpen_out) begin
      log1.push_back({drp1.drpwe_out, drp1.drpaddr_out,
                      drp1.drpwe_out ? drp1.drpdi_out : 16'h0000});
      if (drp1.drpwe_out) mem1[drp1.drpaddr_out] = drp1.drpdi_out;
      rdata1 = mem1[drp1.drpaddr_out];
      busy1  = 1'b1;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared = compared + 1;
    if (observed !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic rdy, input logic am);
    if (inst == 1) begin
      rdy1 = rdy;
      am1  = am;
    end else begin
      rdy3 = rdy;
      am3  = am;
    end
  endtask

  task automatic waitDone(input string tag, input int inst, input int budget);
    int n;
    n = 0;
    while (((inst == 1) ? done1 : done3) !== 1'b1 && n < budget) begin
      tick;
      n++;
    end
    checkOutput(tag, (inst == 1) ? done1 : done3, 1);
  endtask

  // Compares the logged accesses from base against the expected RMW order.
  task automatic checkSeq(input string tag, input int inst, input int base,
                          input int nregs, input logic am);
    int sz;
    int k;
    logic [26:0] e;
    sz = (inst == 1) ? log1.size() : log3.size();
    checkOutput({tag, "_len"}, sz - base, nregs * ACC_PER_ENTRY);
    for (int i = 0; i < nregs; i++) begin
      k = base + i * ACC_PER_ENTRY;
      if (k + ACC_PER_ENTRY <= sz) begin
        e = (inst == 1) ? log1[k] : log3[k];
        checkOutput($sformatf("%s_rd%0d", tag, i), e, {1'b0, exp_addr[i], 16'h0000});
        e = (inst == 1) ? log1[k+1] : log3[k+1];
        checkOutput($sformatf("%s_wr%0d", tag, i), e,
                    {1'b1, exp_addr[i], am ? exp_am[i] : exp_mm[i]});
`ifdef GTF_DRP_RECONFIG_VERIFY_EN
        e = (inst == 1) ? log1[k+2] : log3[k+2];
        checkOutput($sformatf("%s_vfy%0d", tag, i), e, {1'b0, exp_addr[i], 16'h0000});
`endif
      end
    end
  endtask

  initial begin
    int base;
    int r0;
    int e0;
    int n;

    reset = 1'b1;
    applyStimulus(1, 0, 0);
    applyStimulus(3, 0, 0);
    repeat (3) tick;

    $display("[TB] reset state");
    checkOutput("rst_sm3", sm3, ST_IDLE);
    checkOutput("rst_done3", done3, 0);
    checkOutput("rst_err3", err3, 0);
    checkOutput("rst_drp3", {drp3.drpen_out, drp3.drpwe_out, drp3.drpaddr_out, drp3.drpdi_out}, 0);
    checkOutput("rst_sm1", sm1, ST_IDLE);
    checkOutput("rst_out1", {done1, err1, drp1.drpen_out, drp1.drpwe_out}, 0);
    reset = 1'b0;
    tick;

    $display("[TB] MM switch, single entry");
    base = log1.size();
    applyStimulus(1, 1, 0);
    waitDone("mm1_done", 1, 200);
    checkSeq("mm1", 1, base, 1, 1'b0);
    repeat (3) tick;
    checkOutput("mm1_done_held", done1, 1);
    checkOutput("mm1_no_extra", log1.size() - base, ACC_PER_ENTRY);
    applyStimulus(1, 0, 0);
    repeat (5) tick;
    checkOutput("mm1_done_clr", done1, 0);
    checkOutput("mm1_sm_idle", sm1, ST_IDLE);

    $display("[TB] AM switch, three entries, request re-pulsed mid-sequence");
    base = log3.size();
    r0 = rise3;
    applyStimulus(3, 1, 1);
    n = 0;
    while (log3.size() < base + 2 && n < 100) begin
      tick;
      n++;
    end
    applyStimulus(3, 0, 1);
    tick;
    applyStimulus(3, 1, 0);
    waitDone("am3_done", 3, 300);
    checkSeq("am3", 3, base, 3, 1'b1);
    checkOutput("am3_done_lat", ((done_cyc3 - wr_rdy_cyc3) <= 4) ? 1 : 0, 1);
    repeat (4) tick;
    checkOutput("am3_rises", rise3 - r0, 1);
    checkOutput("am3_no_extra", log3.size() - base, 3 * ACC_PER_ENTRY);

    $display("[TB] drop and reassert: second full sequence (MM)");
    applyStimulus(3, 0, 0);
    repeat (5) tick;
    checkOutput("am3_done_clr", done3, 0);
    base = log3.size();
    applyStimulus(3, 1, 0);
    waitDone("mm3_done", 3, 300);
    checkSeq("mm3", 3, base, 3, 1'b0);
    checkOutput("mm3_rises", rise3 - r0, 2);
    applyStimulus(3, 0, 0);
    repeat (5) tick;

    $display("[TB] DRP timeout");
    no_rdy3 = 1'b1;
    e0 = en_cnt3;
    applyStimulus(3, 1, 1);
    n = 0;
    while (en_cnt3 == e0 && n < 50) begin
      tick;
      n++;
    end
    n = 0;
    while (err3 !== 1'b1 && n < 60) begin
      tick;
      n++;
    end
    checkOutput("tmo_cycles", n, 16);
    checkOutput("tmo_sm", sm3, ST_ERROR);
    checkOutput("tmo_done", done3, 0);
    e0 = en_cnt3;
    applyStimulus(3, 0, 1);
    repeat (10) tick;
    applyStimulus(3, 1, 1);
    repeat (10) tick;
    checkOutput("tmo_no_en", en_cnt3 - e0, 0);
    checkOutput("tmo_err_sticky", err3, 1);
    checkOutput("tmo_done_low", done3, 0);

    $display("[TB] reset while in WR_WAIT");
    applyStimulus(3, 0, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    no_rdy3 = 1'b0;
    lat3 = 4;
    repeat (3) tick;
    checkOutput("rwr_err_clr", err3, 0);
    applyStimulus(3, 1, 1);
    n = 0;
    while (sm3 != ST_WR_WAIT && n < 100) begin
      tick;
      n++;
    end
    checkOutput("rwr_reach", sm3, ST_WR_WAIT);
    reset = 1'b1;
    applyStimulus(3, 0, 1);
    tick;
    checkOutput("rwr_sm", sm3, ST_IDLE);
    checkOutput("rwr_drp", {drp3.drpen_out, drp3.drpwe_out, drp3.drpaddr_out, drp3.drpdi_out}, 0);
    checkOutput("rwr_flags", {done3, err3}, 0);
    reset = 1'b0;
    repeat (8) tick;
    base = log3.size();
    applyStimulus(3, 1, 1);
    waitDone("rwr_done", 3, 400);
    checkSeq("rwr", 3, base, 3, 1'b1);
    applyStimulus(3, 0, 1);
    repeat (5) tick;

`ifdef GTF_DRP_RECONFIG_VERIFY_EN
    $display("[TB] verify readback corrupted in bit 8");
    reset = 1'b1;
    tick;
    reset = 1'b0;
    lat3 = 1;
    corrupt3 = 1'b1;
    tick;
    base = log3.size();
    applyStimulus(3, 1, 1);
    n = 0;
    while (err3 !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    checkOutput("vfy_err", err3, 1);
    checkOutput("vfy_sm", sm3, ST_ERROR);
    checkOutput("vfy_done", done3, 0);
    checkOutput("vfy_len", log3.size() - base, 3);
    applyStimulus(3, 0, 1);
    corrupt3 = 1'b0;
    tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gtfwizard_mac_rx_drp_sync_reconfig.md
Name: gtfwizard_mac_rx_drp_sync_reconfig

Overview:
Performs the GTF channel DRP read-modify-write sequence that switches the RX buffer-bypass alignment between manual mode (MM) and auto mode (AM). It consumes the buffer-bypass controller's drp_reconfig_rdy_out and drp_switch_am_out outputs and produces its drp_reconfig_done_in input. It sits between that controller and the GTF channel DRP port, in the DRP clock domain.

Parameters:
P_NUM_REGS, 3, number of active DRP table entries (1..4).
P_REG_ADDR, 40'h0, 4x10-bit packed DRP addresses; entry i is at [10*i+:10].
P_REG_MASK, 64'h0, 4x16-bit packed field masks; a 1 marks a bit to modify.
P_REG_VAL_AM, 64'h0, 4x16-bit packed field values for AM.
P_REG_VAL_MM, 64'h0, 4x16-bit packed field values for MM.
P_DRP_TIMEOUT, 1023, maximum clocks to wait for drprdy per access.

Ports:
gtwiz_drp_reconfig_clk_in  in  1  DRP clock; the only clock.
gtwiz_drp_reconfig_reset_in  in  1  synchronous, active-high reset.
drp_reconfig_rdy_in  in  1  request from the buffbypass controller (async; synchronised internally).
drp_switch_am_in  in  1  1 = apply AM values, 0 = apply MM values (async; synchronised internally).
drp_reconfig_done_out  out  1  level; sequence complete.
drp_reconfig_error_out  out  1  sticky; DRP timeout or verify failure.
drpaddr_out  out  10  DRP address.
drpen_out  out  1  one-cycle DRP strobe.
drpwe_out  out  1  write enable, qualified by drpen_out.
drpdi_out  out  16  write data.
drpdo_in  in  16  read data.
drprdy_in  in  1  DRP access complete.
sm_drp_reconfig_out  out  4  debug: current state encoding.

Behaviour:
- Inputs: drp_reconfig_rdy_in and drp_switch_am_in each pass through a 2-FF synchroniser. A start is the rising edge of the synchronised rdy, giving 3 cycles from pin to start.
- Reset values: every output is 0; the state is IDLE; the entry index is 0; the timeout counter is 0.
- States (4-bit): IDLE=0, RD_REQ=1, RD_WAIT=2, WR_REQ=3, WR_WAIT=4, VFY_REQ=5, VFY_WAIT=6, NEXT=7, DONE=8, ERROR=9.
- IDLE: on start, latch synchronised switch_am into mode_am, clear the index, go to RD_REQ.
- RD_REQ: drpen=1, drpwe=0, drpaddr=ADDR[idx] for exactly 1 cycle, then RD_WAIT.
- RD_WAIT: on drprdy, compute wdata=(drpdo & ~MASK[idx]) | (VAL[idx] & MASK[idx]), where VAL is VAL_AM if mode_am else VAL_MM. Go to WR_REQ.
- WR_REQ: drpen=1, drpwe=1, drpdi=wdata for 1 cycle, then WR_WAIT.
- WR_WAIT: on drprdy go to VFY_REQ if verify is compiled in, else NEXT.
- NEXT: if idx==P_NUM_REGS-1 go to DONE, else idx+1 and RD_REQ.
- DONE: drp_reconfig_done_out=1 and held. When synchronised rdy is 0, clear done and go to IDLE. The done pulse width is therefore at least 1 cycle, and the controller sees a clean posedge.
- Timeout: the counter clears on entry to each *_WAIT state and increments every wait cycle. When it reaches P_DRP_TIMEOUT, error_out=1 and the FSM goes to ERROR with drpen=0.
- ERROR: done stays 0; the FSM leaves only on reset. error_out is sticky until reset.
- drpen_out is never high on two consecutive cycles. drprdy outside a *_WAIT state is ignored.
- A rdy rising edge while not in IDLE is ignored; the sequence in flight is not restarted. switch_am changes mid-sequence are ignored.
- Reset mid-operation returns to IDLE next cycle with drpen=0. A DRP write may be left partially applied; the controller re-requests after its own reset.
- The table index width is 2 bits. P_NUM_REGS=1 performs exactly one RMW.

Optional Feature:
GTF_DRP_RECONFIG_VERIFY_EN
- Defined:
  - After each write, VFY_REQ issues a read of the same address.
  - In VFY_WAIT, ((drpdo ^ wdata) & MASK[idx]) != 0 sets error_out and goes to ERROR; otherwise the FSM goes to NEXT.
  - The timeout rules apply.
- Undefined: VFY_REQ and VFY_WAIT are unreachable and removed; WR_WAIT goes to NEXT. Per entry this costs 2 DRP accesses instead of 3.

Decomposition:
- Package gtfwizard_mac_drp_reconfig_pkg holds:
  - the state encodings;
  - the DRP address/data width constants (10/16);
  - the maximum entry count (4);
  - a function that extracts entry i from the packed parameter vectors.
- One sub-module, gtfwizard_mac_drp_reconfig_sync2, holds the 2-FF synchroniser, instanced twice.

Test Plan:
- MM switch: P_NUM_REGS=1, ADDR=0x05A, MASK=0x0300, VAL_MM=0x0100; DRP model returns 0xFFFF; assert rdy with switch_am=0. Required: one read of 0x05A, one write of 0xFDFF, then done=1 until rdy falls.
- AM switch over 3 entries: exactly 3 read/write pairs in address order with AM values. done rises no later than 4 cycles after the last write's drprdy.
- Timeout: model never returns drprdy; P_DRP_TIMEOUT=15. Required: error_out=1 after 15 wait cycles, done stays 0, no further drpen.
- Re-trigger: pulse rdy again mid-sequence. Required: sequence unchanged, one done rising edge. Drop rdy, then reassert: a second full sequence runs.
- Reset while in WR_WAIT: drpen=0, all outputs 0, state=0 on the next cycle; a new request completes normally.
- With GTF_DRP_RECONFIG_VERIFY_EN, model corrupts the verify readback in bit 8 (MASK=0x0300). Required: error_out=1 and state=ERROR.
